prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter ADDR_W, default 10, width of the memory word address (1024-word memory).
REQ-002 Parameter BASE_ADDR, default 0, word address where the first program word is written.
REQ-003 clk1  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 byte_valid  input  1  a serial byte is offered this cycle.
REQ-006 byte_data  input  8  offered byte.
REQ-007 byte_ready  output  1  loader accepts byte; transfer = byte_valid & byte_ready.
REQ-008 reload  input  1  one-cycle request to discard state and restart loading.
REQ-009 mem_we  output  1  one-cycle write strobe to instruction/data memory.
REQ-010 mem_addr  output  ADDR_W  write word address.
REQ-011 mem_wdata  output  32  write word.
REQ-012 cpu_run  output  1  releases processor clocks/halt; high only after verified load.
REQ-013 load_err  output  1  sticky error flag.

Function
REQ-014 Stream format SHALL be: count_hi, count_lo (16-bit word count N, big-endian), then N words of 4 bytes big-endian (first byte -> bits 31:24), then 1 checksum byte.
REQ-015 Checksum SHALL be the XOR of all 4N payload bytes; header bytes excluded.
REQ-016 FSM states SHALL be HDR_HI, HDR_LO, DATA, CSUM, RUN, ERR.
REQ-017 byte_ready SHALL be 1 in HDR_HI, HDR_LO, DATA, CSUM and 0 in RUN, ERR; no other backpressure.
REQ-018 HDR_HI -> HDR_LO on transfer; HDR_LO -> DATA on transfer if 1 <= N <= 2^ADDR_W, else -> ERR.
REQ-019 In DATA, a 2-bit byte counter SHALL pack bytes; on the 4th byte the word is complete.
REQ-020 mem_we SHALL pulse exactly one cycle, in the cycle after the 4th byte's transfer, with mem_addr = BASE_ADDR + word index (modulo 2^ADDR_W) and mem_wdata = packed word.
REQ-021 Word index SHALL start at 0, increment per completed word; after word N-1 completes, DATA -> CSUM.
REQ-022 CSUM -> RUN if received byte equals the accumulated XOR, else -> ERR.
REQ-023 cpu_run SHALL be 1 only in RUN; load_err SHALL be 1 only in ERR.
REQ-024 reload SHALL in any state return the FSM to HDR_HI, clear counters, checksum, cpu_run, load_err; a byte offered in the same cycle SHALL NOT be accepted (reload wins).
REQ-025 A completed word whose write pulse falls in the reload cycle's successor SHALL be suppressed (no mem_we after reload).
REQ-026 Gaps (byte_valid low) SHALL be permitted at any point without affecting state.

Reset
REQ-027 On rst: state HDR_HI, byte_ready 1 after release, mem_we 0, mem_addr 0, mem_wdata 0, cpu_run 0, load_err 0, all counters and checksum 0.
REQ-028 rst asserted mid-load SHALL abort the load immediately; no mem_we is issued for partial words.

Structure
REQ-029 Shared package loader_pkg SHALL hold the FSM state enum, MAX_WORDS, header/checksum byte counts.
REQ-030 One sub-module byte_packer (4-byte shift register + byte counter + word-complete pulse) is natural; the FSM, address counter and checksum remain in prog_loader.

Verification
REQ-031 Stream 00 01 DE AD BE EF 22 -> one mem_we, addr 0, data DEADBEEF; cpu_run 1 two cycles later; load_err 0.
REQ-032 N=3 words 00000001, 00000002, 00000003, checksum 00, with random byte_valid gaps -> writes at addrs 0,1,2 in order; cpu_run 1.
REQ-033 Header 00 00, and separately 04 01 -> ERR, load_err 1, byte_ready 0, no mem_we.
REQ-034 Stream 00 01 11 22 33 44 00 (correct is 44) -> one write of 11223344, then load_err 1, cpu_run 0.
REQ-035 reload asserted after 2 data bytes, same cycle byte_valid=1 -> byte not accepted, no mem_we; fresh stream then loads correctly.
REQ-036 rst pulsed after 3 of 4 data bytes -> all outputs at reset values, no mem_we; subsequent full stream succeeds.

Source files
------------

// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared types and constants for the serial program loader
package loader_pkg;

    localparam int MAX_WORDS      = 1024;
    localparam int HDR_BYTES      = 2;
    localparam int CSUM_BYTES     = 1;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        ST_HDR_HI,
        ST_HDR_LO,
        ST_DATA,
        ST_CSUM,
        ST_RUN,
        ST_ERR
    } load_state_t;

    // A word count is loadable when it is non-zero and fits the memory.
    function automatic logic words_ok(input logic [15:0] n, input int addr_w);
        if (n == 16'd0)
            return 1'b0;
        if (addr_w >= 16)
            return 1'b1;
        return {1'b0, n} <= (17'd1 << addr_w);
    endfunction

endpackage

// File: rtl/byte_packer.sv
// rtl/byte_packer.sv - packs big-endian bytes into 32-bit words
module byte_packer
    import loader_pkg::*;
(
    input  logic        clk1,
    input  logic        rst,
    input  logic        clear,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic [31:0] word,
    output logic        word_done
);

    logic [1:0]  cnt;
    logic [23:0] shift;

    // The completed word is presented combinationally with the 4th byte.
    assign word_done = in_valid && (cnt == 2'(BYTES_PER_WORD - 1));
    assign word      = {shift, in_data};

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            shift <= '0;
        end else if (clear) begin
            cnt   <= '0;
            shift <= '0;
        end else if (in_valid) begin
            cnt   <= cnt + 2'd1;
            shift <= {shift[15:0], in_data};
        end
    end

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - serial program loader with checksum-gated processor release
module prog_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W    = $clog2(MAX_WORDS),
    parameter int BASE_ADDR = 0
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    input  logic              reload,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_run,
    output logic              load_err
);

    load_state_t state, state_nxt;

    logic        xfer;
    logic        data_xfer;
    logic        word_done;
    logic        last_word;
    logic [31:0] packed_word;
    logic [7:0]  count_hi;
    logic [7:0]  csum;
    logic [15:0] word_count;
    logic [15:0] word_idx;

    assign byte_ready = (state == ST_HDR_HI) || (state == ST_HDR_LO) ||
                        (state == ST_DATA)   || (state == ST_CSUM);
    assign cpu_run    = (state == ST_RUN);
    assign load_err   = (state == ST_ERR);

    // reload wins over a byte offered in the same cycle
    assign xfer      = byte_valid && byte_ready && !reload;
    assign data_xfer = xfer && (state == ST_DATA);
    assign last_word = (word_idx + 16'd1) == word_count;

    byte_packer u_packer (
        .clk1      (clk1),
        .rst       (rst),
        .clear     (reload),
        .in_valid  (data_xfer),
        .in_data   (byte_data),
        .word      (packed_word),
        .word_done (word_done)
    );

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst)
            state <= ST_HDR_HI;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_HDR_HI: if (xfer) state_nxt = ST_HDR_LO;
            ST_HDR_LO: if (xfer) state_nxt = words_ok({count_hi, byte_data}, ADDR_W) ? ST_DATA : ST_ERR;
            ST_DATA:   if (word_done && last_word) state_nxt = ST_CSUM;
            ST_CSUM:   if (xfer) state_nxt = (byte_data == csum) ? ST_RUN : ST_ERR;
            ST_RUN:    state_nxt = ST_RUN;
            ST_ERR:    state_nxt = ST_ERR;
            default:   state_nxt = ST_HDR_HI;
        endcase
        if (reload)
            state_nxt = ST_HDR_HI;
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            count_hi   <= '0;
            word_count <= '0;
            word_idx   <= '0;
            csum       <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else if (reload) begin
            count_hi   <= '0;
            word_count <= '0;
            word_idx   <= '0;
            csum       <= '0;
            mem_we     <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            if (xfer && state == ST_HDR_HI)
                count_hi <= byte_data;
            if (xfer && state == ST_HDR_LO) begin
                word_count <= {count_hi, byte_data};
                word_idx   <= '0;
                csum       <= '0;
            end
            if (data_xfer)
                csum <= csum ^ byte_data;
            if (word_done) begin
                mem_we    <= 1'b1;
                mem_addr  <= ADDR_W'(BASE_ADDR) + word_idx[ADDR_W-1:0];
                mem_wdata <= packed_word;
                word_idx  <= word_idx + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - directed self-checking bench for prog_loader
module tb_prog_loader;

    logic        clk1 = 1'b0;
    logic        rst = 1'b1;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_ready;
    logic        reload = 1'b0;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_run;
    logic        load_err;

    int n_checks = 0;
    int n_errors = 0;
    int wr_cnt = 0;
    int wr_base = 0;
    logic [9:0]  wr_addr [0:31];
    logic [31:0] wr_data [0:31];
    logic [7:0]  stream [$];

    prog_loader dut (
        .clk1       (clk1),
        .rst        (rst),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .reload     (reload),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_run    (cpu_run),
        .load_err   (load_err)
    );

    always #5 clk1 = ~clk1;

    always @(negedge clk1) begin
        if (mem_we === 1'b1) begin
            if (wr_cnt < 32) begin
                wr_addr[wr_cnt] = mem_addr;
                wr_data[wr_cnt] = mem_wdata;
            end
            wr_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk1);
        check("ready_when_offered", {31'd0, byte_ready}, 32'd1);
        byte_valid = 1'b1;
        byte_data  = b;
        @(posedge clk1);
        #1 byte_valid = 1'b0;
    endtask

    task automatic send_stream(input bit gaps);
        foreach (stream[i]) begin
            if (gaps)
                repeat ($urandom_range(0, 2)) @(posedge clk1);
            send_byte(stream[i]);
        end
        @(negedge clk1);
        @(negedge clk1);
    endtask

    task automatic do_reload();
        @(negedge clk1);
        reload = 1'b1;
        @(posedge clk1);
        #1 reload = 1'b0;
        @(negedge clk1);
        wr_base = wr_cnt;
    endtask

    task automatic check_write(input string tag, input int idx, input logic [9:0] a, input logic [31:0] d);
        check({tag, "_addr"}, {22'd0, wr_addr[wr_base + idx]}, {22'd0, a});
        check({tag, "_data"}, wr_data[wr_base + idx], d);
    endtask

    initial begin
        repeat (2) @(negedge clk1);
        check("rst_mem_we",    {31'd0, mem_we},   32'd0);
        check("rst_mem_addr",  {22'd0, mem_addr}, 32'd0);
        check("rst_mem_wdata", mem_wdata,         32'd0);
        check("rst_cpu_run",   {31'd0, cpu_run},  32'd0);
        check("rst_load_err",  {31'd0, load_err}, 32'd0);
        rst = 1'b0;
        @(negedge clk1);
        check("rst_byte_ready", {31'd0, byte_ready}, 32'd1);

        // single word, good checksum
        stream = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
        send_stream(1'b0);
        check("one_word_count", wr_cnt - wr_base, 32'd1);
        check_write("one_word", 0, 10'd0, 32'hDEADBEEF);
        check("one_word_run",   {31'd0, cpu_run},    32'd1);
        check("one_word_err",   {31'd0, load_err},   32'd0);
        check("run_not_ready",  {31'd0, byte_ready}, 32'd0);

        do_reload();
        check("reload_clears_run", {31'd0, cpu_run},    32'd0);
        check("reload_ready",      {31'd0, byte_ready}, 32'd1);

        // three words with random gaps
        stream = '{8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02,
                   8'h00, 8'h00, 8'h00, 8'h03, 8'h00};
        send_stream(1'b1);
        check("three_count", wr_cnt - wr_base, 32'd3);
        check_write("three_w0", 0, 10'd0, 32'h00000001);
        check_write("three_w1", 1, 10'd1, 32'h00000002);
        check_write("three_w2", 2, 10'd2, 32'h00000003);
        check("three_run", {31'd0, cpu_run}, 32'd1);

        // zero word count
        do_reload();
        stream = '{8'h00, 8'h00};
        send_stream(1'b0);
        check("n0_err",    {31'd0, load_err},   32'd1);
        check("n0_ready",  {31'd0, byte_ready}, 32'd0);
        check("n0_run",    {31'd0, cpu_run},    32'd0);
        check("n0_writes", wr_cnt - wr_base,    32'd0);

        // word count 1025 exceeds the 1024-word memory
        do_reload();
        check("reload_clears_err", {31'd0, load_err}, 32'd0);
        stream = '{8'h04, 8'h01};
        send_stream(1'b0);
        check("n1025_err",    {31'd0, load_err},   32'd1);
        check("n1025_ready",  {31'd0, byte_ready}, 32'd0);
        check("n1025_writes", wr_cnt - wr_base,    32'd0);

        // bad checksum: word is still written, then error
        do_reload();
        stream = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
        send_stream(1'b0);
        check("badcs_count", wr_cnt - wr_base, 32'd1);
        check_write("badcs", 0, 10'd0, 32'h11223344);
        check("badcs_err", {31'd0, load_err}, 32'd1);
        check("badcs_run", {31'd0, cpu_run},  32'd0);

        // reload with a byte offered in the same cycle
        do_reload();
        stream = '{8'h00, 8'h01, 8'hAA, 8'hBB};
        send_stream(1'b0);
        @(negedge clk1);
        reload     = 1'b1;
        byte_valid = 1'b1;
        byte_data  = 8'hCC;
        @(posedge clk1);
        #1 reload = 1'b0;
        byte_valid = 1'b0;
        repeat (3) @(negedge clk1);
        check("reload_byte_writes", wr_cnt - wr_base, 32'd0);
        check("reload_byte_ready",  {31'd0, byte_ready}, 32'd1);
        stream = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
        send_stream(1'b0);
        check("after_reload_count", wr_cnt - wr_base, 32'd1);
        check_write("after_reload", 0, 10'd0, 32'h12345678);
        check("after_reload_run", {31'd0, cpu_run}, 32'd1);

        // asynchronous reset after 3 of 4 data bytes
        do_reload();
        stream = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h03};
        send_stream(1'b0);
        #2 rst = 1'b1;
        #1;
        check("midrst_mem_we",    {31'd0, mem_we},     32'd0);
        check("midrst_mem_addr",  {22'd0, mem_addr},   32'd0);
        check("midrst_mem_wdata", mem_wdata,           32'd0);
        check("midrst_run",       {31'd0, cpu_run},    32'd0);
        check("midrst_err",       {31'd0, load_err},   32'd0);
        repeat (2) @(negedge clk1);
        rst = 1'b0;
        @(negedge clk1);
        check("midrst_writes", wr_cnt - wr_base, 32'd0);
        check("midrst_ready",  {31'd0, byte_ready}, 32'd1);
        stream = '{8'h00, 8'h01, 8'hCA, 8'hFE, 8'hBA, 8'hBE, 8'h30};
        send_stream(1'b0);
        check("post_rst_count", wr_cnt - wr_base, 32'd1);
        check_write("post_rst", 0, 10'd0, 32'hCAFEBABE);
        check("post_rst_run", {31'd0, cpu_run},  32'd1);
        check("post_rst_err", {31'd0, load_err}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
